// File: rtl/data_memory_responder.sv
// data_memory_responder: data-side word memory for the CPU bus, with self-clear after reset, error flag and write counter
module data_memory_responder #(
  parameter int unsigned DEPTH_WORDS  = 1024,
  parameter logic [31:0] BASE_ADDRESS = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clk_enable,
  input  logic [31:0] data_address,
  input  logic        data_write,
  input  logic        data_read,
  input  logic [31:0] data_writedata,
  output logic [31:0] data_readdata,
  output logic        init_done,
  output logic        access_error,
  output logic [31:0] write_count
);
  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam logic [31:0] SPAN = 32'(DEPTH_WORDS) << 2;
  localparam logic [AW-1:0] LAST = AW'(DEPTH_WORDS - 1);
  typedef enum logic {CLEAR, READY} state_t;
  state_t state_q, state_d;
  logic [AW-1:0] clear_idx_q, clear_idx_d;
  logic err_q, err_d;
  logic [31:0] wc_q, wc_d;
  logic [31:0] mem_q [DEPTH_WORDS];
  logic [31:0] offset;
  logic [AW-1:0] idx;
  logic ready, valid, req, bad, wr_en;
  // Addresses below BASE wrap to a huge offset and so fall out of range too.
  assign offset = data_address - BASE_ADDRESS;
  assign idx    = offset[AW+1:2];
  assign ready  = state_q == READY;
  assign valid  = (offset < SPAN) && (data_address[1:0] == 2'b00) && ready;
  assign req    = data_read | data_write;
  assign bad    = req & (!valid | (data_read & data_write));
  assign wr_en  = data_write & !data_read & valid;
  assign data_readdata = (data_read && valid) ? mem_q[idx] : 32'h0;
  assign init_done     = ready;
  assign access_error  = err_q;
  assign write_count   = wc_q;
  always_comb begin
    state_d     = (clk_enable && !ready && clear_idx_q == LAST) ? READY : state_q;
    clear_idx_d = (clk_enable && !ready) ? clear_idx_q + 1'b1 : clear_idx_q;
    err_d       = err_q | (clk_enable & bad);
    wc_d        = (clk_enable && wr_en) ? wc_q + 32'd1 : wc_q;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= CLEAR;
      clear_idx_q <= '0;
      err_q       <= 1'b0;
      wc_q        <= '0;
    end else begin
      state_q     <= state_d;
      clear_idx_q <= clear_idx_d;
      err_q       <= err_d;
      wc_q        <= wc_d;
    end
  end
  // The array has no reset; an edge seen while reset_n is low must not write it.
  always_ff @(posedge clk) begin
    if (reset_n && clk_enable) begin
      if (!ready) mem_q[clear_idx_q] <= 32'h0;
      else if (wr_en) mem_q[idx] <= data_writedata;
    end
  end
endmodule

// File: tb/tb_data_memory_responder.sv
// tb_data_memory_responder: directed scoreboard bench for data_memory_responder (DEPTH_WORDS=4, BASE=0x1000)
module tb_data_memory_responder;
  logic        clk = 1'b0;
  logic        reset_n, clk_enable, data_write, data_read;
  logic [31:0] data_address, data_writedata, data_readdata, write_count;
  logic        init_done, access_error;
  int          errors = 0;
  int          checks = 0;
  logic [31:0] model [4];
  logic [31:0] model_wc;
  logic [31:0] exp_q [$];

  data_memory_responder #(.DEPTH_WORDS(4), .BASE_ADDRESS(32'h1000)) dut (
    .clk(clk), .reset_n(reset_n), .clk_enable(clk_enable),
    .data_address(data_address), .data_write(data_write), .data_read(data_read),
    .data_writedata(data_writedata), .data_readdata(data_readdata),
    .init_done(init_done), .access_error(access_error), .write_count(write_count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    data_read = 1'b0;
    data_write = 1'b0;
    data_address = 32'h0;
    data_writedata = 32'h0;
  endtask

  task automatic rd(input string tag, input logic [31:0] addr);
    data_read = 1'b1;
    data_write = 1'b0;
    data_address = addr;
    exp_q.push_back((addr >= 32'h1000 && addr < 32'h1010 && addr[1:0] == 2'b00) ? model[addr[3:2]] : 32'h0);
    #1;
    chk(tag, data_readdata, exp_q.pop_front());
    data_read = 1'b0;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] d);
    data_read = 1'b0;
    data_write = 1'b1;
    data_address = addr;
    data_writedata = d;
    step();
    if (addr >= 32'h1000 && addr < 32'h1010 && addr[1:0] == 2'b00) begin
      model[addr[3:2]] = d;
      model_wc = model_wc + 1;
    end
    idle();
  endtask

  initial begin
    for (int i = 0; i < 4; i++) model[i] = 32'h0;
    model_wc = 0;
    reset_n = 1'b0;
    clk_enable = 1'b0;
    idle();
    #12;
    chk("rst_readdata", data_readdata, 32'h0);
    chk("rst_init_done", {31'h0, init_done}, 32'h0);
    chk("rst_error", {31'h0, access_error}, 32'h0);
    chk("rst_wcount", write_count, 32'h0);
    // 1: clear latency is exactly 4 enabled edges
    reset_n = 1'b1;
    clk_enable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("clear_edge%0d_init_done", i), {31'h0, init_done}, {31'h0, i == 3});
    end
    rd("post_clear_rd_1008", 32'h1008);
    // 2: write visible only after the edge
    data_write = 1'b1;
    data_address = 32'h1008;
    data_writedata = 32'hDEADBEEF;
    #1;
    chk("same_cycle_readdata", data_readdata, 32'h0);
    step();
    model[2] = 32'hDEADBEEF;
    model_wc++;
    idle();
    rd("rd_after_wr_1008", 32'h1008);
    chk("wcount_after_wr", write_count, model_wc);
    chk("err_after_good_wr", {31'h0, access_error}, 32'h0);
    // 4: out-of-range and misaligned writes are dropped and flagged
    wr(32'h1010, 32'hBAD0BAD0);
    chk("err_out_of_range", {31'h0, access_error}, 32'h1);
    wr(32'h1002, 32'hBAD1BAD1);
    chk("wcount_after_bad_wr", write_count, model_wc);
    rd("rd_out_of_range", 32'h1010);
    rd("rd_misaligned", 32'h1002);
    rd("rd_1000_untouched", 32'h1000);
    // 3: simultaneous read+write: read serviced with old data, write dropped
    data_read = 1'b1;
    data_write = 1'b1;
    data_address = 32'h1008;
    data_writedata = 32'h12345678;
    #1;
    chk("rw_read_serviced", data_readdata, 32'hDEADBEEF);
    step();
    idle();
    rd("rw_write_dropped", 32'h1008);
    chk("wcount_after_rw", write_count, model_wc);
    // more legal writes
    wr(32'h1000, 32'h0000_0011);
    wr(32'h100C, 32'h0000_0022);
    rd("rd_1000", 32'h1000);
    rd("rd_100C", 32'h100C);
    rd("rd_1004", 32'h1004);
    chk("wcount_three", write_count, model_wc);
    // 5: clock enable low freezes everything
    clk_enable = 1'b0;
    data_write = 1'b1;
    data_address = 32'h1000;
    data_writedata = 32'hCAFEF00D;
    for (int i = 0; i < 3; i++) step();
    idle();
    clk_enable = 1'b1;
    rd("rd_gated_write", 32'h1000);
    chk("wcount_gated", write_count, model_wc);
    // 6: reset during a write abandons it; outputs clear immediately
    data_write = 1'b1;
    data_address = 32'h1004;
    data_writedata = 32'h55AA55AA;
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("rst_mid_wr_wcount", write_count, 32'h0);
    chk("rst_mid_wr_init_done", {31'h0, init_done}, 32'h0);
    chk("rst_mid_wr_error", {31'h0, access_error}, 32'h0);
    step();
    idle();
    for (int i = 0; i < 4; i++) model[i] = 32'h0;
    model_wc = 0;
    reset_n = 1'b1;
    // access during clear is flagged and returns zero
    data_read = 1'b1;
    data_address = 32'h1000;
    #1;
    chk("rd_during_clear", data_readdata, 32'h0);
    step();
    idle();
    chk("err_during_clear", {31'h0, access_error}, 32'h1);
    step();
    reset_n = 1'b0;
    #1;
    chk("rst_mid_clear_error", {31'h0, access_error}, 32'h0);
    chk("rst_mid_clear_init", {31'h0, init_done}, 32'h0);
    step();
    reset_n = 1'b1;
    step();
    step();
    clk_enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("gated_clear%0d_init_done", i), {31'h0, init_done}, 32'h0);
    end
    clk_enable = 1'b1;
    step();
    chk("clear_edge3_init_done_restart", {31'h0, init_done}, 32'h0);
    step();
    chk("clear_edge4_init_done_restart", {31'h0, init_done}, 32'h1);
    for (int i = 0; i < 4; i++) rd($sformatf("rd_after_reclear_%0d", i), 32'h1000 + 32'(4 * i));
    chk("wcount_after_reclear", write_count, 32'h0);
    chk("err_after_reclear", {31'h0, access_error}, 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
